// File: rtl/trng_autocorr_pkg.sv
// Shared definitions for the TRNG autocorrelation health test: FSM encoding,
// default window/threshold constants and the score-width helper.
package trng_autocorr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_SCAN    = 3'd3,
        ST_EVAL    = 3'd4
    } state_t;

    localparam int          PMF_W          = 14;
    localparam int          WINDOW_DEF     = 120;
    localparam int          MAX_LAG_DEF    = 4;
    localparam int          FAIL_LIMIT_DEF = 2;
    localparam logic [15:0] SCORE_TH_DEF   = 16'd4000;

    // Sum of max_lag scores of PMF_W bits each cannot overflow this width.
    function automatic int score_width(input int max_lag);
        return PMF_W + $clog2(max_lag);
    endfunction

endpackage

// File: rtl/trng_autocorr_lag_cnt.sv
// History shift register plus one match counter per lag (1..MAX_LAG),
// with synchronous clear, prime-only shifting and a lag-select read mux.
module trng_autocorr_lag_cnt #(
    parameter int MAX_LAG = 4,
    parameter int ADDR_W  = 8,
    localparam int SEL_W  = $clog2(MAX_LAG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              count_en,
    input  logic              bit_data,
    input  logic [SEL_W-1:0]  sel,
    output logic [ADDR_W-1:0] cnt_sel
);

    logic [MAX_LAG-1:0] hist_vec;
    logic [ADDR_W-1:0]  cnt_arr [MAX_LAG];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAG; gi++) begin : g_lag
            logic              hist_reg;
            logic [ADDR_W-1:0] cnt_reg;
            logic              hist_in;

            // hist_vec[k-1] holds the bit seen k transfers ago
            if (gi == 0) begin : g_head
                assign hist_in = bit_data;
            end else begin : g_tail
                assign hist_in = hist_vec[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else if (clr) begin
                    hist_reg <= 1'b0;
                    cnt_reg  <= '0;
                end else begin
                    if (shift_en || count_en) begin
                        hist_reg <= hist_in;
                    end
                    if (count_en && (bit_data == hist_reg)) begin
                        cnt_reg <= cnt_reg + ADDR_W'(1);
                    end
                end
            end

            assign hist_vec[gi] = hist_reg;
            assign cnt_arr[gi]  = cnt_reg;
        end
    endgenerate

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < MAX_LAG; i++) begin
            if (sel == SEL_W'(i + 1)) begin
                cnt_sel = cnt_arr[i];
            end
        end
    end

endmodule

// File: rtl/trng_autocorr_test.sv
// Streaming autocorrelation health test: counts per-lag bit matches over a window,
// scores them through an external pmf_table and raises a sticky error after
// FAIL_LIMIT consecutive failing windows. Define TRNG_AUTOCORR_STATS_EN for worst_lag/worst_pmf.
module trng_autocorr_test
    import trng_autocorr_pkg::*;
#(
    parameter int          WINDOW     = WINDOW_DEF,
    parameter int          MAX_LAG    = MAX_LAG_DEF,
    parameter int          ADDR_W     = 8,
    parameter logic [15:0] SCORE_TH   = SCORE_TH_DEF,
    parameter int          FAIL_LIMIT = FAIL_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              test_en,
    input  logic              bit_valid,
    input  logic              bit_data,
    output logic              bit_ready,
    output logic [ADDR_W-1:0] pmf_addr_out,
    input  logic [PMF_W-1:0]  pmf_data_in,
    output logic              win_done,
    output logic              win_fail,
    output logic              autocorr_err
`ifdef TRNG_AUTOCORR_STATS_EN
    ,
    output logic [$clog2(MAX_LAG+1)-1:0] worst_lag,
    output logic [PMF_W-1:0]             worst_pmf
`endif
);

    localparam int SCORE_W = score_width(MAX_LAG);
    localparam int SEL_W   = $clog2(MAX_LAG + 1);
    localparam int BC_W    = $clog2(WINDOW);
    localparam int FC_W    = $clog2(FAIL_LIMIT + 1);

    state_t             state_reg, state_next;
    logic [BC_W-1:0]    bit_cnt_reg;
    logic [SEL_W-1:0]   lag_idx_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [FC_W-1:0]    fail_cnt_reg;
    logic               err_reg;
    logic [ADDR_W-1:0]  cnt_sel;
    logic               xfer, prime_last, collect_last, score_fail;

    assign bit_ready    = (state_reg == ST_PRIME) || (state_reg == ST_COLLECT);
    assign xfer         = bit_valid && bit_ready;
    assign prime_last   = (bit_cnt_reg == BC_W'(MAX_LAG - 1));
    assign collect_last = (bit_cnt_reg == BC_W'(WINDOW - 1));
    assign score_fail   = (32'(score_reg) > 32'(SCORE_TH));

    assign win_done     = (state_reg == ST_EVAL);
    assign win_fail     = win_done && score_fail;
    assign autocorr_err = err_reg;
    assign pmf_addr_out = (state_reg == ST_SCAN) ? cnt_sel : '0;

    trng_autocorr_lag_cnt #(
        .MAX_LAG (MAX_LAG),
        .ADDR_W  (ADDR_W)
    ) u_lag_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!test_en || (state_reg == ST_EVAL)),
        .shift_en ((state_reg == ST_PRIME) && xfer),
        .count_en ((state_reg == ST_COLLECT) && xfer),
        .bit_data (bit_data),
        .sel      (lag_idx_reg),
        .cnt_sel  (cnt_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (test_en) state_next = ST_PRIME;
            ST_PRIME:   if (xfer && prime_last) state_next = ST_COLLECT;
            ST_COLLECT: if (xfer && collect_last) state_next = ST_SCAN;
            ST_SCAN:    if (lag_idx_reg == SEL_W'(MAX_LAG)) state_next = ST_EVAL;
            ST_EVAL:    state_next = ST_PRIME;
            default:    state_next = ST_IDLE;
        endcase
        if (!test_en) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg  <= '0;
            lag_idx_reg  <= '0;
            score_reg    <= '0;
            fail_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (!test_en) begin
            bit_cnt_reg  <= '0;
            lag_idx_reg  <= '0;
            score_reg    <= '0;
            fail_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_PRIME: begin
                    if (xfer) bit_cnt_reg <= prime_last ? '0 : bit_cnt_reg + BC_W'(1);
                end
                ST_COLLECT: begin
                    if (xfer) begin
                        bit_cnt_reg <= collect_last ? '0 : bit_cnt_reg + BC_W'(1);
                        if (collect_last) lag_idx_reg <= SEL_W'(1);
                    end
                end
                ST_SCAN: begin
                    score_reg   <= score_reg + SCORE_W'(pmf_data_in);
                    lag_idx_reg <= lag_idx_reg + SEL_W'(1);
                end
                ST_EVAL: begin
                    score_reg   <= '0;
                    lag_idx_reg <= '0;
                    bit_cnt_reg <= '0;
                    // Consecutive-fail counter saturates; the error stays until disable/reset
                    if (score_fail) begin
                        if (fail_cnt_reg < FC_W'(FAIL_LIMIT)) fail_cnt_reg <= fail_cnt_reg + FC_W'(1);
                        if (fail_cnt_reg >= FC_W'(FAIL_LIMIT - 1)) err_reg <= 1'b1;
                    end else begin
                        fail_cnt_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRNG_AUTOCORR_STATS_EN
    logic [SEL_W-1:0] best_lag_reg, worst_lag_reg;
    logic [PMF_W-1:0] best_pmf_reg, worst_pmf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_lag_reg  <= '0;
            best_pmf_reg  <= '0;
            worst_lag_reg <= '0;
            worst_pmf_reg <= '0;
        end else if (!test_en) begin
            best_lag_reg <= '0;
            best_pmf_reg <= '0;
        end else if (state_reg == ST_SCAN) begin
            // Strict compare keeps the lowest lag on ties
            if ((lag_idx_reg == SEL_W'(1)) || (pmf_data_in > best_pmf_reg)) begin
                best_lag_reg <= lag_idx_reg;
                best_pmf_reg <= pmf_data_in;
            end
        end else if (state_reg == ST_EVAL) begin
            worst_lag_reg <= best_lag_reg;
            worst_pmf_reg <= best_pmf_reg;
        end
    end

    assign worst_lag = worst_lag_reg;
    assign worst_pmf = worst_pmf_reg;
`endif

endmodule

// File: tb/tb_trng_autocorr_test.sv
// Scoreboard bench for trng_autocorr_test: a reference autocorrelation model predicts
// per-lag counts, pass/fail and the sticky error for each window; a negedge monitor checks them.
module tb_trng_autocorr_test;

    localparam int NBITS = 124;

    typedef struct packed {
        logic [3:0][7:0] cnt;
        logic            fail;
        logic            err;
        logic            cont;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, test_en, bit_valid, bit_data;
    logic        bit_ready, win_done, win_fail, autocorr_err;
    logic [7:0]  pmf_addr_out;
    logic [13:0] pmf_data_in;
`ifdef TRNG_AUTOCORR_STATS_EN
    logic [2:0]  worst_lag;
    logic [13:0] worst_pmf;
`endif

    trng_autocorr_test dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .test_en      (test_en),
        .bit_valid    (bit_valid),
        .bit_data     (bit_data),
        .bit_ready    (bit_ready),
        .pmf_addr_out (pmf_addr_out),
        .pmf_data_in  (pmf_data_in),
        .win_done     (win_done),
        .win_fail     (win_fail),
        .autocorr_err (autocorr_err)
`ifdef TRNG_AUTOCORR_STATS_EN
        ,
        .worst_lag    (worst_lag),
        .worst_pmf    (worst_pmf)
`endif
    );

    always #5 clk = ~clk;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t sb_q[$];
    int   fcnt_m = 0;
    logic err_m  = 1'b0;

    task automatic check(input string tag, input int observed, input int expected);
        n_compared++;
        if (observed != expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // pmf_table stand-in: score depends on the distance of the count from WINDOW/2
    function automatic int pmf_f(input int a);
        int d;
        d = (a > 60) ? a - 60 : 60 - a;
        if (d == 0)  return 0;
        if (d == 30) return 3848;
        if (d == 60) return 10979;
        return d * 40;
    endfunction

    always_comb pmf_data_in = 14'(pmf_f(int'(pmf_addr_out)));

    // ---------------- stimulus ----------------
    task automatic drive_bit(input logic b);
        int guard;
        bit_valid = 1'b1;
        bit_data  = b;
        guard     = 0;
        @(negedge clk);
        while (!bit_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bit_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_window(input logic [NBITS-1:0] b, input logic gaps, input logic push, input int nbits);
        exp_t e;
        int   s, c;
        if (push) begin
            s = 0;
            for (int k = 1; k <= 4; k++) begin
                c = 0;
                for (int n = 4; n < NBITS; n++) if (b[n] == b[n-k]) c++;
                e.cnt[k-1] = 8'(c);
                s += pmf_f(c);
            end
            e.fail = (s > 4000);
            if (e.fail) begin
                if (fcnt_m < 2) fcnt_m++;
                if (fcnt_m >= 2) err_m = 1'b1;
            end else begin
                fcnt_m = 0;
            end
            e.err  = err_m;
            e.cont = !gaps;
            sb_q.push_back(e);
            $display("window pushed: cnt=%0d/%0d/%0d/%0d score=%0d fail=%0b err=%0b",
                     e.cnt[0], e.cnt[1], e.cnt[2], e.cnt[3], s, e.fail, e.err);
        end
        for (int i = 0; i < nbits; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bit_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            drive_bit(b[i]);
        end
    endtask

    function automatic logic [NBITS-1:0] make_pattern();
        logic [7:0]       pat;
        logic [NBITS-1:0] r;
        pat = 8'b1110_1000;  // first bit in LSB: 0,0,0,1,0,1,1,1
        for (int i = 0; i < NBITS; i++) r[i] = pat[i % 8];
        return r;
    endfunction

    function automatic logic [NBITS-1:0] make_random();
        logic [NBITS-1:0] r;
        for (int i = 0; i < NBITS; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("sb_drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    int         phase = 0, xfers = 0, cyc = 0, last_done = 0, low_run = 0;
    logic       have_last = 1'b0, err_pend = 1'b0, exp_err = 1'b0, run_had_done = 1'b0;
    logic [7:0] addr_cap [4];

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n || !test_en) begin
            phase = 0; xfers = 0; have_last = 1'b0; err_pend = 1'b0;
            low_run = 0; run_had_done = 1'b0;
        end else begin
            if (!bit_ready) begin
                low_run++;
            end else begin
                if (run_had_done) check("ready_low_cycles", low_run, 5);
                low_run = 0;
                run_had_done = 1'b0;
            end
            if (phase == 0) begin
                if (err_pend) begin
                    check("autocorr_err", autocorr_err, exp_err);
                    err_pend = 1'b0;
                end
                if (win_done) check("unexpected_win_done", win_done, 0);
                if (bit_valid && bit_ready) xfers++;
                if (xfers == NBITS) begin
                    phase = 1;
                    xfers = 0;
                end
            end else if (phase <= 4) begin
                addr_cap[phase-1] = pmf_addr_out;
                phase++;
            end else begin
                phase = 0;
                run_had_done = 1'b1;
                check("win_done", win_done, 1);
                check("addr_idle_eval", pmf_addr_out, 0);
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    for (int k = 0; k < 4; k++) check($sformatf("lag%0d_cnt", k + 1), addr_cap[k], e.cnt[k]);
                    check("win_fail", win_fail, e.fail);
                    if (e.cont && have_last) check("done_spacing", cyc - last_done, 129);
                    exp_err  = e.err;
                    err_pend = 1'b1;
                    $display("window done: cnt=%0d/%0d/%0d/%0d win_fail=%0b", addr_cap[0], addr_cap[1],
                             addr_cap[2], addr_cap[3], win_fail);
                end
                have_last = 1'b1;
                last_done = cyc;
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        logic [NBITS-1:0] zeros;
        logic [NBITS-1:0] pattern;
        zeros     = '0;
        pattern   = make_pattern();
        rst_n     = 1'b0;
        test_en   = 1'b0;
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        #3;
        check("rst_bit_ready", bit_ready, 0);
        check("rst_win_done", win_done, 0);
        check("rst_win_fail", win_fail, 0);
        check("rst_autocorr_err", autocorr_err, 0);
        check("rst_pmf_addr", pmf_addr_out, 0);
        repeat (2) @(negedge clk);
        #3;
        rst_n   = 1'b1;
        test_en = 1'b1;

        // two all-zero windows: both fail, error after the second
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drain();

        // disable clears the sticky error
        test_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("err_cleared_by_en", autocorr_err, 0);
        fcnt_m = 0; err_m = 1'b0;
        test_en = 1'b1;

        // fail / pass / fail never reaches the limit
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drive_window(pattern, 1'b0, 1'b1, NBITS);
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drive_window(make_random(), 1'b1, 1'b1, NBITS);
        drive_window(pattern, 1'b1, 1'b1, NBITS);

        // abort after 4 prime + 50 collect bits, then a fresh pattern window
        drive_window(pattern, 1'b0, 1'b0, 54);
        bit_valid = 1'b0;
        test_en   = 1'b0;
        fcnt_m = 0; err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bit_ready_after_drop", bit_ready, 0);
        test_en = 1'b1;
        drive_window(pattern, 1'b0, 1'b1, NBITS);

        // raise the error, then reset in the middle of SCAN
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        drive_window(zeros, 1'b0, 1'b0, NBITS);
        bit_valid = 1'b0;
        check("err_before_rst", autocorr_err, 1);
        @(negedge clk);
        check("scan_addr_before_rst", pmf_addr_out, 120);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_scan_addr", pmf_addr_out, 0);
        check("rst_scan_err", autocorr_err, 0);
        check("rst_scan_done", win_done, 0);
        check("rst_scan_ready", bit_ready, 0);
        fcnt_m = 0; err_m = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        drive_window(pattern, 1'b0, 1'b1, NBITS);
        drive_window(zeros, 1'b0, 1'b1, NBITS);
        bit_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
